// File: rtl/gpio_debounce.sv
// gpio_debounce: multi-channel pad synchroniser and tick-based debouncer.
// Each channel synchronises its pad, counts prescaler ticks while the synchronised
// value differs from the accepted level, and accepts the new value after db_len ticks.
// Edge pulses and sticky event flags are reported per channel.
module gpio_debounce #(
  parameter int unsigned CH          = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PRESC_W     = 16,
  parameter int unsigned DB_W        = 8,
  parameter logic        RESET_LEVEL = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PRESC_W-1:0] presc_div,
  input  logic [DB_W-1:0]    db_len,
  input  logic [CH-1:0]      pad_i,
  input  logic [CH-1:0]      evt_clr_i,
  output logic               tick_o,
  output logic [CH-1:0]      level_o,
  output logic [CH-1:0]      rise_o,
  output logic [CH-1:0]      fall_o,
  output logic [CH-1:0]      evt_o
);

  localparam logic [PRESC_W-1:0] PrescOne = PRESC_W'(1);
  localparam logic [DB_W:0]      DbOne    = (DB_W + 1)'(1);
  localparam logic [DB_W-1:0]    DbLenMin = DB_W'(1);

  // Synchroniser chain; stage SYNC_STAGES-1 is the only view of the pads.
  logic [CH-1:0] sync_q [SYNC_STAGES];
  logic [CH-1:0] sync_d [SYNC_STAGES];
  logic [CH-1:0] sync_s;

  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic               presc_hit;

  logic [DB_W-1:0] db_cnt_q [CH];
  logic [DB_W-1:0] db_cnt_d [CH];
  logic [DB_W-1:0] db_len_eff;
  logic [DB_W:0]   db_inc;

  logic [CH-1:0] level_q, level_d;
  logic [CH-1:0] rise_q, rise_d;
  logic [CH-1:0] fall_q, fall_d;
  logic [CH-1:0] evt_q, evt_d;

  // Shift each pad one stage further down its synchroniser chain.
  always_comb begin
    sync_d[0] = pad_i;
    for (int k = 1; k < int'(SYNC_STAGES); k++) begin
      sync_d[k] = sync_q[k-1];
    end
    sync_s = sync_q[SYNC_STAGES-1];
  end

  // Prescaler: tick whenever the count has reached presc_div, then wrap.
  // Using >= lets a lowered presc_div tick immediately instead of overflowing.
  always_comb begin
    presc_hit   = (presc_cnt_q >= presc_div);
    presc_cnt_d = presc_hit ? '0 : presc_cnt_q + PrescOne;
    tick_o      = presc_hit & ~reset;
  end

  // Per-channel debounce: count ticks while the synchronised input differs from
  // the accepted level; any agreement clears the count (bounce rejection).
  always_comb begin
    db_len_eff = (db_len == '0) ? DbLenMin : db_len;
    db_inc     = '0;
    level_d    = level_q;
    rise_d     = '0;
    fall_d     = '0;
    for (int i = 0; i < int'(CH); i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      db_inc      = {1'b0, db_cnt_q[i]} + DbOne;
      if (sync_s[i] == level_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (presc_hit) begin
        if (db_inc >= {1'b0, db_len_eff}) begin
          level_d[i]  = sync_s[i];
          db_cnt_d[i] = '0;
          rise_d[i]   = sync_s[i];
          fall_d[i]   = ~sync_s[i];
        end else begin
          db_cnt_d[i] = db_inc[DB_W-1:0];
        end
      end
    end
  end

  // Sticky event flags: a reported edge wins over a simultaneous clear.
  always_comb begin
    evt_d = (evt_q & ~evt_clr_i) | rise_q | fall_q;
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < int'(SYNC_STAGES); k++) begin
        sync_q[k] <= {CH{RESET_LEVEL}};
      end
      for (int i = 0; i < int'(CH); i++) begin
        db_cnt_q[i] <= '0;
      end
      presc_cnt_q <= '0;
      level_q     <= {CH{RESET_LEVEL}};
      rise_q      <= '0;
      fall_q      <= '0;
      evt_q       <= '0;
    end else begin
      for (int k = 0; k < int'(SYNC_STAGES); k++) begin
        sync_q[k] <= sync_d[k];
      end
      for (int i = 0; i < int'(CH); i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
      presc_cnt_q <= presc_cnt_d;
      level_q     <= level_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      evt_q       <= evt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign evt_o   = evt_q;

endmodule
